// File: rtl/regs_sb_pkg.sv
// Shared constants for the integer register file with busy-bit scoreboard.
// Default geometry matches the base RV32 integer register file.
package regs_sb_pkg;

    localparam int REG_NUM      = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int REG_W        = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG  = '0;
    localparam logic [REG_W-1:0]      ZERO_WORD = '0;

    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic RST_ENABLE   = 1'b0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_W-1:0]      reg_t;

endpackage

// File: rtl/regs_sb_bypass.sv
// Priority mux of the write-back ports for one read port.
// The lowest-index matching port wins; x0 never hits.
module regs_sb_bypass #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NWR  = 2
) (
    input  logic [NWR-1:0]      wen_i,
    input  logic [NWR*AW-1:0]   w_addr_i,
    input  logic [NWR*XLEN-1:0] w_data_i,
    input  logic [AW-1:0]       r_addr_i,
    output logic                hit_o,
    output logic [XLEN-1:0]     data_o
);

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        // Walk from lowest to highest priority so the last assignment wins.
        for (int k = NWR - 1; k >= 0; k--) begin
            if (wen_i[k] && (w_addr_i[k*AW +: AW] == r_addr_i) && (r_addr_i != '0)) begin
                hit_o  = 1'b1;
                data_o = w_data_i[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/regs_sb.sv
// Integer register file with NRD read ports, NWR prioritised write ports,
// write-to-read bypass and a busy-bit scoreboard for RAW hazard detection.
module regs_sb
    import regs_sb_pkg::*;
#(
    parameter int XLEN  = REG_W,
    parameter int NREGS = REG_NUM,
    parameter int AW    = REG_ADDR_W,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      wen_i,
    input  logic [NWR*AW-1:0]   w_addr_i,
    input  logic [NWR*XLEN-1:0] w_data_i,
    input  logic [NRD*AW-1:0]   r_addr_i,
    output logic [NRD*XLEN-1:0] r_data_o,
    output logic [NRD-1:0]      r_busy_o,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i,
    input  logic                flush_i,
    output logic [NREGS-1:0]    busy_o
);

    logic [NREGS-1:0][XLEN-1:0] regs_q;
    logic [NREGS-1:0]           busy_q;
    logic [NREGS-1:0]           busy_nxt;

    // Storage: walk low to high priority so port 0 lands last on a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            regs_q <= '0;
        end else begin
            for (int k = NWR - 1; k >= 0; k--) begin
                if ((wen_i[k] == WRITE_ENABLE) && (w_addr_i[k*AW +: AW] != '0))
                    regs_q[w_addr_i[k*AW +: AW]] <= w_data_i[k*XLEN +: XLEN];
            end
        end
    end

    // Issue is applied after write-back clears so a new producer stays pending.
    always_comb begin
        busy_nxt = busy_q;
        if (flush_i) begin
            busy_nxt = '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wen_i[k] && (w_addr_i[k*AW +: AW] != '0))
                    busy_nxt[w_addr_i[k*AW +: AW]] = 1'b0;
            end
            if (iss_en_i && (iss_addr_i != '0))
                busy_nxt[iss_addr_i] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE)
            busy_q <= '0;
        else
            busy_q <= busy_nxt;
    end

    assign busy_o = busy_q;

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic            hit;
        logic [XLEN-1:0] byp_data;
        logic [AW-1:0]   addr;

        assign addr = r_addr_i[j*AW +: AW];

        regs_sb_bypass #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_byp (
            .wen_i    (wen_i),
            .w_addr_i (w_addr_i),
            .w_data_i (w_data_i),
            .r_addr_i (addr),
            .hit_o    (hit),
            .data_o   (byp_data)
        );

        always_comb begin
            if (addr == '0) begin
                r_data_o[j*XLEN +: XLEN] = '0;
                r_busy_o[j]              = 1'b0;
            end else if (hit) begin
                r_data_o[j*XLEN +: XLEN] = byp_data;
                r_busy_o[j]              = 1'b0;
            end else begin
                r_data_o[j*XLEN +: XLEN] = regs_q[addr];
                r_busy_o[j]              = busy_q[addr];
            end
        end
    end

endmodule

// File: tb/tb_regs_sb.sv
// Directed bench for regs_sb: storage, bypass priority, x0 handling,
// scoreboard set/clear/flush and asynchronous reset.
module tb_regs_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NWR-1:0]      wen_i;
    logic [NWR*AW-1:0]   w_addr_i;
    logic [NWR*XLEN-1:0] w_data_i;
    logic [NRD*AW-1:0]   r_addr_i;
    logic [NRD*XLEN-1:0] r_data_o;
    logic [NRD-1:0]      r_busy_o;
    logic                iss_en_i;
    logic [AW-1:0]       iss_addr_i;
    logic                flush_i;
    logic [NREGS-1:0]    busy_o;

    int tests = 0;
    int fails = 0;

    regs_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .NWR(NWR)) dut (
        .clk        (clk),
        .rst        (rst),
        .wen_i      (wen_i),
        .w_addr_i   (w_addr_i),
        .w_data_i   (w_data_i),
        .r_addr_i   (r_addr_i),
        .r_data_o   (r_data_o),
        .r_busy_o   (r_busy_o),
        .iss_en_i   (iss_en_i),
        .iss_addr_i (iss_addr_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] rd(input int j);
        return r_data_o[j*XLEN +: XLEN];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int k, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wen_i[k]              = 1'b1;
        w_addr_i[k*AW +: AW]  = a;
        w_data_i[k*XLEN +: XLEN] = d;
    endtask

    task automatic set_r(input int j, input logic [AW-1:0] a);
        r_addr_i[j*AW +: AW] = a;
    endtask

    task automatic idle();
        wen_i    = '0;
        w_addr_i = '0;
        w_data_i = '0;
        iss_en_i = 1'b0;
        iss_addr_i = '0;
        flush_i  = 1'b0;
    endtask

    task automatic test_reset();
        int bad_d;
        int bad_b;
        bad_d = 0;
        bad_b = 0;
        rst = 1'b0;
        idle();
        r_addr_i = '0;
        #2;
        for (int a = 1; a < NREGS; a++) begin
            set_r(0, a[AW-1:0]);
            #1;
            if (rd(0) !== '0 || r_busy_o[0] !== 1'b0) bad_d++;
            if (busy_o !== '0) bad_b++;
        end
        tests++;
        if (bad_d != 0) begin fails++; $display("FAIL reset_rdata bad reads %0d required 0", bad_d); end
        tests++;
        if (bad_b != 0) begin fails++; $display("FAIL reset_busy bad samples %0d required 0", bad_b); end
        tick();
        rst = 1'b1;
        tick();
        set_r(0, 5'd1);
        set_r(1, 5'd31);
        #1;
        tests++;
        if (rd(0) !== 32'h0 || rd(1) !== 32'h0 || busy_o !== '0) begin
            fails++;
            $display("FAIL post_reset got %h %h busy %h required 0", rd(0), rd(1), busy_o);
        end
    endtask

    task automatic test_priority();
        set_w(0, 5'd7, 32'hAAAA_0000);
        set_w(1, 5'd7, 32'h5555_FFFF);
        set_r(0, 5'd7);
        set_r(1, 5'd7);
        #1;
        tests++;
        if (rd(0) !== 32'hAAAA_0000 || rd(1) !== 32'hAAAA_0000) begin
            fails++;
            $display("FAIL prio_bypass got %h %h required aaaa0000", rd(0), rd(1));
        end
        tick();
        idle();
        #1;
        tests++;
        if (rd(0) !== 32'hAAAA_0000) begin
            fails++;
            $display("FAIL prio_store got %h required aaaa0000", rd(0));
        end
        // Port 1 alone may still write when port 0 is idle.
        set_w(1, 5'd13, 32'h1313_1313);
        set_r(1, 5'd13);
        #1;
        tests++;
        if (rd(1) !== 32'h1313_1313) begin
            fails++;
            $display("FAIL port1_bypass got %h required 13131313", rd(1));
        end
        tick();
        idle();
        #1;
        tests++;
        if (rd(1) !== 32'h1313_1313) begin
            fails++;
            $display("FAIL port1_store got %h required 13131313", rd(1));
        end
    endtask

    task automatic test_x0();
        set_w(0, 5'd0, 32'hDEAD_BEEF);
        set_r(0, 5'd0);
        #1;
        tests++;
        if (rd(0) !== 32'h0 || r_busy_o[0] !== 1'b0) begin
            fails++;
            $display("FAIL x0_bypass got %h busy %b required 0", rd(0), r_busy_o[0]);
        end
        tick();
        idle();
        iss_en_i = 1'b1;
        iss_addr_i = 5'd0;
        tick();
        idle();
        #1;
        tests++;
        if (rd(0) !== 32'h0 || busy_o !== '0) begin
            fails++;
            $display("FAIL x0_store got %h busy %h required 0", rd(0), busy_o);
        end
    endtask

    task automatic test_scoreboard();
        iss_en_i = 1'b1;
        iss_addr_i = 5'd5;
        tick();
        idle();
        set_r(0, 5'd5);
        #1;
        tests++;
        if (r_busy_o[0] !== 1'b1 || busy_o !== 32'h0000_0020) begin
            fails++;
            $display("FAIL sb_set got rbusy %b busy %h required 1 00000020", r_busy_o[0], busy_o);
        end
        set_w(1, 5'd5, 32'h0000_1234);
        #1;
        tests++;
        if (r_busy_o[0] !== 1'b0 || rd(0) !== 32'h0000_1234) begin
            fails++;
            $display("FAIL sb_fwd got rbusy %b data %h required 0 00001234", r_busy_o[0], rd(0));
        end
        tick();
        idle();
        #1;
        tests++;
        if (busy_o[5] !== 1'b0 || rd(0) !== 32'h0000_1234 || r_busy_o[0] !== 1'b0) begin
            fails++;
            $display("FAIL sb_clear got busy5 %b data %h required 0 00001234", busy_o[5], rd(0));
        end
    endtask

    task automatic test_issue_wb();
        iss_en_i = 1'b1;
        iss_addr_i = 5'd9;
        set_w(0, 5'd9, 32'h0000_0099);
        tick();
        idle();
        set_r(0, 5'd9);
        #1;
        tests++;
        if (busy_o !== 32'h0000_0200 || r_busy_o[0] !== 1'b1) begin
            fails++;
            $display("FAIL iss_wb_busy got %h rbusy %b required 00000200 1", busy_o, r_busy_o[0]);
        end
        tests++;
        if (rd(0) !== 32'h0000_0099) begin
            fails++;
            $display("FAIL iss_wb_data got %h required 00000099", rd(0));
        end
    endtask

    task automatic test_back_to_back();
        set_w(0, 5'd10, 32'h0000_010A);
        set_w(1, 5'd11, 32'h0000_011B);
        set_r(0, 5'd10);
        set_r(1, 5'd11);
        #1;
        tests++;
        if (rd(0) !== 32'h0000_010A || rd(1) !== 32'h0000_011B) begin
            fails++;
            $display("FAIL b2b_bypass got %h %h required 0000010a 0000011b", rd(0), rd(1));
        end
        tick();
        idle();
        set_w(0, 5'd10, 32'h0000_020A);
        #1;
        tests++;
        if (rd(0) !== 32'h0000_020A || rd(1) !== 32'h0000_011B) begin
            fails++;
            $display("FAIL b2b_second got %h %h required 0000020a 0000011b", rd(0), rd(1));
        end
        tick();
        idle();
        #1;
        tests++;
        if (rd(0) !== 32'h0000_020A) begin
            fails++;
            $display("FAIL b2b_store got %h required 0000020a", rd(0));
        end
    endtask

    task automatic test_flush();
        iss_en_i = 1'b1;
        iss_addr_i = 5'd3;
        tick();
        iss_addr_i = 5'd4;
        tick();
        iss_addr_i = 5'd6;
        tick();
        idle();
        #1;
        tests++;
        if (busy_o !== 32'h0000_0258) begin
            fails++;
            $display("FAIL flush_pre got %h required 00000258", busy_o);
        end
        flush_i = 1'b1;
        iss_en_i = 1'b1;
        iss_addr_i = 5'd8;
        set_w(0, 5'd12, 32'h00C0_FFEE);
        tick();
        idle();
        set_r(0, 5'd12);
        set_r(1, 5'd8);
        #1;
        tests++;
        if (busy_o !== '0 || r_busy_o[1] !== 1'b0) begin
            fails++;
            $display("FAIL flush_busy got %h required 00000000", busy_o);
        end
        tests++;
        if (rd(0) !== 32'h00C0_FFEE) begin
            fails++;
            $display("FAIL flush_write got %h required 00c0ffee", rd(0));
        end
    endtask

    task automatic test_mid_reset();
        iss_en_i = 1'b1;
        iss_addr_i = 5'd20;
        set_w(0, 5'd21, 32'h2121_2121);
        tick();
        idle();
        set_r(0, 5'd21);
        #1;
        tests++;
        if (rd(0) !== 32'h2121_2121 || busy_o !== 32'h0010_0000) begin
            fails++;
            $display("FAIL pre_areset got %h busy %h required 21212121 00100000", rd(0), busy_o);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (rd(0) !== 32'h0 || busy_o !== '0) begin
            fails++;
            $display("FAIL areset got %h busy %h required 0", rd(0), busy_o);
        end
        #1;
        rst = 1'b1;
        tick();
        #1;
        tests++;
        if (rd(0) !== 32'h0 || busy_o !== '0) begin
            fails++;
            $display("FAIL post_areset got %h busy %h required 0", rd(0), busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_x0();
        test_scoreboard();
        test_issue_wb();
        test_back_to_back();
        test_flush();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
